// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Generates the PC, runs a single-outstanding
// req/ack transaction on the instruction bus, and presents {pc, inst, valid} to
// the IF/ID register. A one-entry buffer absorbs a fetch completed under stall.
module if_fetch #(
  parameter int              WD       = 32,
  parameter logic [WD-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [WD-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rest,
  input  logic          jump_flag_i,
  input  logic [WD-1:0] jump_addr_i,
  input  logic          hold_flag_i,
  output logic          ibus_req_o,
  output logic [WD-1:0] ibus_addr_o,
  input  logic          ibus_ack_i,
  input  logic [WD-1:0] ibus_rdata_i,
  output logic [WD-1:0] if_pc_o,
  output logic [WD-1:0] if_inst_o,
  output logic          if_valid_o,
  output logic          ifid_refresh_o
);

  // IDLE  : one cycle after reset, no request
  // REQ   : request outstanding at r_pc
  // HOLD  : fetched word parked in the buffer while downstream stalls
  // DRAIN : redirect arrived mid-request; finish the old request, drop its data
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [WD-1:0] r_pc;          // address of the current / next request
  logic [WD-1:0] w_pc_next;
  logic [WD-1:0] r_tgt;         // redirect target remembered while draining
  logic [WD-1:0] w_tgt_next;

  logic [WD-1:0] r_if_pc;
  logic [WD-1:0] w_if_pc_next;
  logic [WD-1:0] r_if_inst;
  logic [WD-1:0] w_if_inst_next;
  logic          r_if_valid;
  logic          w_if_valid_next;

  logic [WD-1:0] r_buf_pc;
  logic [WD-1:0] w_buf_pc_next;
  logic [WD-1:0] r_buf_inst;
  logic [WD-1:0] w_buf_inst_next;
  logic          r_buf_valid;
  logic          w_buf_valid_next;

  logic [WD-1:0] w_jump_pc;
  logic [WD-1:0] w_pc_inc;
  logic [1:0]    w_unused_addr_bits;

  // Redirect targets are forced to word alignment; the low bits are don't-care.
  assign w_jump_pc          = {jump_addr_i[WD-1:2], 2'b00};
  assign w_unused_addr_bits = jump_addr_i[1:0];
  // Natural modulo-2^WD wrap of the PC.
  assign w_pc_inc           = r_pc + WD'(4);

  // Bus request is held through DRAIN so the old transaction completes cleanly.
  assign ibus_req_o     = (r_state == ST_REQ) || (r_state == ST_DRAIN);
  assign ibus_addr_o    = r_pc;
  assign if_pc_o        = r_if_pc;
  assign if_inst_o      = r_if_inst;
  assign if_valid_o     = r_if_valid;
  // IF/ID loads its NOP on a redirect or whenever nothing valid is presented.
  assign ifid_refresh_o = jump_flag_i | ~r_if_valid;

  // Next-state and datapath selection; a redirect outranks everything else.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_tgt_next       = r_tgt;
    w_if_pc_next     = r_if_pc;
    w_if_inst_next   = r_if_inst;
    w_if_valid_next  = r_if_valid;
    w_buf_pc_next    = r_buf_pc;
    w_buf_inst_next  = r_buf_inst;
    w_buf_valid_next = r_buf_valid;

    if (jump_flag_i) begin
      // Flush presented instruction and any buffered one, even under hold.
      w_if_valid_next  = 1'b0;
      w_if_inst_next   = NOP_INST;
      w_buf_valid_next = 1'b0;
      unique case (r_state)
        ST_IDLE, ST_HOLD: begin
          w_pc_next    = w_jump_pc;
          w_state_next = ST_REQ;
        end
        ST_REQ, ST_DRAIN: begin
          if (ibus_ack_i) begin
            // Old request completes now; its data is simply not used.
            w_pc_next    = w_jump_pc;
            w_state_next = ST_REQ;
          end else begin
            // Request still in flight: keep address, remember target.
            w_tgt_next   = w_jump_pc;
            w_state_next = ST_DRAIN;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_next = ST_REQ;
        end
        ST_REQ: begin
          if (ibus_ack_i) begin
            w_pc_next = w_pc_inc;
            if (hold_flag_i) begin
              // Park the word; outputs must not move while stalled.
              w_buf_pc_next    = r_pc;
              w_buf_inst_next  = ibus_rdata_i;
              w_buf_valid_next = 1'b1;
              w_state_next     = ST_HOLD;
            end else begin
              w_if_pc_next    = r_pc;
              w_if_inst_next  = ibus_rdata_i;
              w_if_valid_next = 1'b1;
            end
          end else if (!hold_flag_i) begin
            // Waiting on the bus: present a bubble.
            w_if_valid_next = 1'b0;
            w_if_inst_next  = NOP_INST;
          end
        end
        ST_HOLD: begin
          if (!hold_flag_i) begin
            w_if_pc_next     = r_buf_pc;
            w_if_inst_next   = r_buf_inst;
            w_if_valid_next  = r_buf_valid;
            w_buf_valid_next = 1'b0;
            w_state_next     = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (ibus_ack_i) begin
            w_pc_next    = r_tgt;
            w_state_next = ST_REQ;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rest) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_tgt       <= RESET_PC;
      r_if_pc     <= RESET_PC;
      r_if_inst   <= NOP_INST;
      r_if_valid  <= 1'b0;
      r_buf_pc    <= RESET_PC;
      r_buf_inst  <= NOP_INST;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_tgt       <= w_tgt_next;
      r_if_pc     <= w_if_pc_next;
      r_if_inst   <= w_if_inst_next;
      r_if_valid  <= w_if_valid_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_inst  <= w_buf_inst_next;
      r_buf_valid <= w_buf_valid_next;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch. A small bus model
// answers requests after a programmable number of wait cycles with
// rdata = addr ^ 32'hA5A5_0000.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk;
  logic        rest;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        ifid_refresh_o;

  int tests_run;
  int tests_failed;

  // bus model controls
  int   bus_wait;
  logic bus_en;
  logic man_ack;
  int   wait_cnt;

  if_fetch #(
    .WD(32), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk), .rest(rest),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o),
    .ifid_refresh_o(ifid_refresh_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ibus_ack_i   = (bus_en && ibus_req_o && (wait_cnt == bus_wait)) || man_ack;
  assign ibus_rdata_i = ibus_addr_o ^ XK;

  always @(posedge clk) begin
    if (!ibus_req_o || ibus_ack_i) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  // one line per accepted bus transaction
  always @(posedge clk) begin
    if (rest && ibus_req_o && ibus_ack_i)
      $display("[TB] t=%0t ack addr=%08h rdata=%08h jump=%0b hold=%0b",
               $time, ibus_addr_o, ibus_rdata_i, jump_flag_i, hold_flag_i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reset for two edges, then release; returns just after E0 (state REQ)
  task automatic do_reset();
    rest = 1'b0; jump_flag_i = 1'b0; hold_flag_i = 1'b0;
    man_ack = 1'b0; bus_en = 1'b1; bus_wait = 0;
    tick(); tick();
    rest = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rest = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0;
    bus_en = 1'b1; bus_wait = 0; man_ack = 1'b0;
    tick(); tick();
    tests_run++; if (ibus_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%0b exp=0", ibus_req_o); end
    tests_run++; if (ibus_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%08h exp=00000000", ibus_addr_o); end
    tests_run++; if (if_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%0b exp=0", if_valid_o); end
    tests_run++; if (if_inst_o !== NOP) begin tests_failed++; $display("FAIL reset_inst got=%08h exp=%08h", if_inst_o, NOP); end
    tests_run++; if (if_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%08h exp=00000000", if_pc_o); end
    tests_run++; if (ifid_refresh_o !== 1'b1) begin tests_failed++; $display("FAIL reset_refresh got=%0b exp=1", ifid_refresh_o); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    rest = 1'b1;
    tick(); // E0
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL zw_first_req req=%0b addr=%08h valid=%0b exp 1/00000000/0", ibus_req_o, ibus_addr_o, if_valid_o);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_pc = 32'(4 * k);
      tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc || if_inst_o !== (exp_pc ^ XK)) begin
        tests_failed++; $display("FAIL zw_out k=%0d got v=%0b pc=%08h inst=%08h exp pc=%08h inst=%08h", k, if_valid_o, if_pc_o, if_inst_o, exp_pc, exp_pc ^ XK);
      end
      tests_run++; if (ibus_addr_o !== exp_pc + 32'd4 || ifid_refresh_o !== 1'b0) begin
        tests_failed++; $display("FAIL zw_addr k=%0d got addr=%08h refresh=%0b exp addr=%08h refresh=0", k, ibus_addr_o, ifid_refresh_o, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_wait2();
    logic        exp_v;
    logic [31:0] exp_addr;
    do_reset();
    bus_wait = 2;
    for (int j = 0; j < 9; j++) begin
      tick();
      exp_v    = ((j % 3) == 2);
      exp_addr = 32'(4 * ((j + 1) / 3));
      tests_run++; if (if_valid_o !== exp_v || ifid_refresh_o !== ~exp_v) begin
        tests_failed++; $display("FAIL w2_valid j=%0d got v=%0b refresh=%0b exp v=%0b", j, if_valid_o, ifid_refresh_o, exp_v);
      end
      tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== exp_addr) begin
        tests_failed++; $display("FAIL w2_addr j=%0d got req=%0b addr=%08h exp 1/%08h", j, ibus_req_o, ibus_addr_o, exp_addr);
      end
      if (exp_v) begin
        tests_run++; if (if_pc_o !== exp_addr - 32'd4 || if_inst_o !== ((exp_addr - 32'd4) ^ XK)) begin
          tests_failed++; $display("FAIL w2_data j=%0d got pc=%08h inst=%08h exp pc=%08h", j, if_pc_o, if_inst_o, exp_addr - 32'd4);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    tick(); tick(); tick(); tick(); // presented pc=0x0C, request at 0x10
    hold_flag_i = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      tests_run++; if (if_pc_o !== 32'h0C || if_valid_o !== 1'b1 || if_inst_o !== (32'h0C ^ XK)) begin
        tests_failed++; $display("FAIL hold_frozen h=%0d got pc=%08h v=%0b inst=%08h exp pc=0000000c v=1", h, if_pc_o, if_valid_o, if_inst_o);
      end
      tests_run++; if (ibus_req_o !== 1'b0) begin tests_failed++; $display("FAIL hold_req h=%0d got=%0b exp=0", h, ibus_req_o); end
    end
    hold_flag_i = 1'b0;
    tick();
    tests_run++; if (if_pc_o !== 32'h10 || if_inst_o !== (32'h10 ^ XK) || if_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL hold_release got pc=%08h inst=%08h v=%0b exp pc=00000010", if_pc_o, if_inst_o, if_valid_o);
    end
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h14) begin
      tests_failed++; $display("FAIL hold_nextreq got req=%0b addr=%08h exp 1/00000014", ibus_req_o, ibus_addr_o);
    end
    tick();
    tests_run++; if (if_pc_o !== 32'h14 || if_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL hold_after got pc=%08h v=%0b exp pc=00000014 v=1", if_pc_o, if_valid_o);
    end
  endtask

  task automatic test_jump_drain();
    do_reset();
    bus_wait = 2;
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0103;
    tick();
    jump_flag_i = 1'b0;
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_inst_o !== NOP || ifid_refresh_o !== 1'b1) begin
      tests_failed++; $display("FAIL drain_enter got req=%0b addr=%08h v=%0b inst=%08h ref=%0b exp 1/00000000/0/NOP/1", ibus_req_o, ibus_addr_o, if_valid_o, if_inst_o, ifid_refresh_o);
    end
    tick();
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL drain_wait got req=%0b addr=%08h v=%0b exp 1/00000000/0", ibus_req_o, ibus_addr_o, if_valid_o);
    end
    tick(); // ack of the old request lands here and is dropped
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL drain_exit got req=%0b addr=%08h v=%0b exp 1/00000100/0", ibus_req_o, ibus_addr_o, if_valid_o);
    end
    bus_wait = 0;
    tick();
    tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_inst_o !== 32'hA5A5_0100) begin
      tests_failed++; $display("FAIL drain_target got v=%0b pc=%08h inst=%08h exp 1/00000100/a5a50100", if_valid_o, if_pc_o, if_inst_o);
    end
  endtask

  task automatic test_jump_ack_hold();
    do_reset();
    tick(); // pc 0 presented, request at 4 with ack
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0040; hold_flag_i = 1'b1;
    tick();
    jump_flag_i = 1'b0; hold_flag_i = 1'b0;
    tests_run++; if (if_valid_o !== 1'b0 || if_inst_o !== NOP) begin
      tests_failed++; $display("FAIL jah_flush got v=%0b inst=%08h exp 0/%08h", if_valid_o, if_inst_o, NOP);
    end
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h40) begin
      tests_failed++; $display("FAIL jah_req got req=%0b addr=%08h exp 1/00000040", ibus_req_o, ibus_addr_o);
    end
    tick();
    tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40 || if_inst_o !== (32'h40 ^ XK)) begin
      tests_failed++; $display("FAIL jah_target got v=%0b pc=%08h inst=%08h exp 1/00000040", if_valid_o, if_pc_o, if_inst_o);
    end
  endtask

  task automatic test_reset_mid();
    // reset while draining, then a stray ack in IDLE
    do_reset();
    bus_wait = 2;
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0080;
    tick();
    jump_flag_i = 1'b0;
    rest = 1'b0;
    tick();
    tests_run++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_inst_o !== NOP || if_pc_o !== 32'h0 || ifid_refresh_o !== 1'b1) begin
      tests_failed++; $display("FAIL rst_drain got req=%0b addr=%08h v=%0b inst=%08h pc=%08h ref=%0b", ibus_req_o, ibus_addr_o, if_valid_o, if_inst_o, if_pc_o, ifid_refresh_o);
    end
    rest = 1'b1; bus_en = 1'b0; man_ack = 1'b1;
    tick(); // E0 with a late ack
    man_ack = 1'b0; bus_en = 1'b1; bus_wait = 0;
    tests_run++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_lateack got req=%0b addr=%08h v=%0b exp 1/00000000/0", ibus_req_o, ibus_addr_o, if_valid_o);
    end
    tick();
    tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== XK) begin
      tests_failed++; $display("FAIL rst_first got v=%0b pc=%08h inst=%08h exp 1/00000000/a5a50000", if_valid_o, if_pc_o, if_inst_o);
    end
    // reset while holding
    hold_flag_i = 1'b1;
    tick(); // ack at 4 under hold -> HOLD
    rest = 1'b0;
    tick();
    hold_flag_i = 1'b0;
    tests_run++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_inst_o !== NOP || if_pc_o !== 32'h0) begin
      tests_failed++; $display("FAIL rst_hold got req=%0b addr=%08h v=%0b inst=%08h pc=%08h", ibus_req_o, ibus_addr_o, if_valid_o, if_inst_o, if_pc_o);
    end
    rest = 1'b1;
    tick(); tick();
    tests_run++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || ibus_addr_o !== 32'h4) begin
      tests_failed++; $display("FAIL rst_hold_refetch got v=%0b pc=%08h addr=%08h exp 1/00000000/00000004", if_valid_o, if_pc_o, ibus_addr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFE;
    tick();
    jump_flag_i = 1'b0;
    tests_run++; if (ibus_addr_o !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_target got=%08h exp=fffffffc", ibus_addr_o);
    end
    tick();
    tests_run++; if (if_pc_o !== 32'hFFFF_FFFC || if_inst_o !== 32'h5A5A_FFFC || ibus_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_pc got pc=%08h inst=%08h addr=%08h exp fffffffc/5a5afffc/00000000", if_pc_o, if_inst_o, ibus_addr_o);
    end
    tick();
    tests_run++; if (if_pc_o !== 32'h0 || if_valid_o !== 1'b1 || ibus_addr_o !== 32'h4) begin
      tests_failed++; $display("FAIL wrap_next got pc=%08h v=%0b addr=%08h exp 00000000/1/00000004", if_pc_o, if_valid_o, ibus_addr_o);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rest = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0;
    bus_en = 1'b1; bus_wait = 0; man_ack = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait2();
    test_hold();
    test_jump_drain();
    test_jump_ack_hold();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
